// File: rtl/execute_md_pkg.sv
// execute_md_pkg: shared RV32I types for the execute stage with the iterative M unit.
// Holds opcode/ALU/compare/mux encodings, the control word, the stage_regs bundle,
// the RV32M op encoding (funct3) and the M-unit state type.
package execute_md_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic {
    ALUMUX1_RS1 = 1'b0,
    ALUMUX1_PC  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    ALUMUX2_I   = 3'd0,
    ALUMUX2_U   = 3'd1,
    ALUMUX2_B   = 3'd2,
    ALUMUX2_S   = 3'd3,
    ALUMUX2_RS2 = 3'd4,
    ALUMUX2_J   = 3'd5
  } alumux2_sel_t;

  typedef enum logic {
    CMPMUX_RS2 = 1'b0,
    CMPMUX_I   = 1'b1
  } cmpmux_sel_t;

  // RV32M ops, encoded directly by funct3
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

  typedef struct packed {
    rv32i_opcode    opcode;
    alu_ops         aluop;
    branch_funct3_t cmpop;
    alumux1_sel_t   alumux1_sel;
    alumux2_sel_t   alumux2_sel;
    cmpmux_sel_t    cmpmux_sel;
    logic           pcmux_sel;
    logic           load_regfile;
    logic           read_b;
    logic           write;
    logic           muldiv;
    logic [2:0]     funct3;
    logic [4:0]     rd;
  } rv32i_control_word;

  typedef struct packed {
    logic              valid;
    rv32i_control_word ctrl;
    rv32i_word         pc;
    rv32i_word         rs1_out;
    rv32i_word         rs2_out;
    rv32i_word         i_imm;
    rv32i_word         u_imm;
    rv32i_word         b_imm;
    rv32i_word         s_imm;
    rv32i_word         j_imm;
    rv32i_word         alu;
    rv32i_word         br;
  } stage_regs;

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/execute_md_muldiv_iter.sv
// muldiv_iter: iterative RV32M unit, one shift-add / restoring-subtract step per cycle.
// Ports: clk, reset (async, active-high); start/op/a/b issue an op while idle;
//        ack releases a finished result; done flags a held result; result is the
//        signed-corrected, half-selected output valid while done is high.
module muldiv_iter
  import execute_md_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t    r_state;
  muldiv_op_t       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;   // product upper half, or partial remainder
  logic [WIDTH-1:0] r_lo;   // multiplier / product lower half, or dividend -> quotient
  logic [WIDTH-1:0] r_d;    // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0] r_a;    // raw rs1 for the special-case results
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_ovf;

  logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_is_div;
  logic             w_div0, w_ovf;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  // Operand decode at issue time
  always_comb begin
    w_a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    w_b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    w_a_neg    = w_a_signed & a[WIDTH-1];
    w_b_neg    = w_b_signed & b[WIDTH-1];
    w_a_abs    = w_a_neg ? -a : a;
    w_b_abs    = w_b_neg ? -b : b;
    w_is_div   = md_is_div(op);
    w_div0     = w_is_div && (b == '0);
    w_ovf      = ((op == MD_DIV) || (op == MD_REM)) && (a == MIN_NEG) && (b == '1);
  end

  logic [WIDTH:0]   w_sum, w_tmp;
  logic [WIDTH-1:0] w_diff, w_step_hi, w_step_lo;
  logic             w_ge;

  // One iteration step; the divide difference is taken mod 2^WIDTH since it is
  // only used when the trial value is not below the divisor
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
    w_tmp  = {r_hi, r_lo[WIDTH-1]};
    w_ge   = (w_tmp >= {1'b0, r_d});
    w_diff = w_tmp[WIDTH-1:0] - r_d;
    if (md_is_div(r_op)) begin
      w_step_hi = w_ge ? w_diff : w_tmp[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // M-unit FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_op    <= MD_MUL;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_d     <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_a_abs : w_b_abs;
            r_d     <= w_is_div ? w_b_abs : w_a_abs;
            r_a     <= a;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_state <= (EARLY_OUT && (w_div0 || w_ovf)) ? MD_DONE : MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= MD_DONE;
        end
        MD_DONE: begin
          if (ack) r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  // Sign correction and half/field selection of the held result
  always_comb begin
    w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo  = r_neg_q ? -r_lo : r_lo;
    w_rem  = r_neg_r ? -r_hi : r_hi;
    case (r_op)
      MD_MUL:                      result = w_prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:             result = r_div0 ? '1 : (r_ovf ? r_a : w_quo);
      default:                     result = r_div0 ? r_a : (r_ovf ? '0 : w_rem);
    endcase
  end

  assign done = (r_state == MD_DONE);

endmodule

// File: rtl/execute_md.sv
// execute_md: RV32 execute stage with ALU/CMP and an iterative RV32M unit.
// Ports: clk, reset (async, active-high); resp_a/resp_b memory responses gate the
//        stage register; stall_in downstream stall; regs_in decode bundle;
//        regs_out registered bundle to memory; stall_out stall to upstream stages.
// WIDTH must not exceed XLEN; M results are zero-extended into the alu field.
module execute_md
  import execute_md_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      resp_a,
  input  logic      resp_b,
  input  logic      stall_in,
  input  stage_regs regs_in,
  output stage_regs regs_out,
  output logic      stall_out
);

  rv32i_word        w_alu_a, w_alu_b, w_cmp_b, w_alu_out;
  logic             w_br_en;
  logic             w_mop, w_load, w_md_start, w_md_ack, w_md_done;
  logic [WIDTH-1:0] w_md_result;
  stage_regs        w_normal, w_next;
  stage_regs        r_regs;

  // Operand muxes
  always_comb begin
    w_alu_a = (regs_in.ctrl.alumux1_sel == ALUMUX1_PC) ? regs_in.pc : regs_in.rs1_out;
    case (regs_in.ctrl.alumux2_sel)
      ALUMUX2_I:   w_alu_b = regs_in.i_imm;
      ALUMUX2_U:   w_alu_b = regs_in.u_imm;
      ALUMUX2_B:   w_alu_b = regs_in.b_imm;
      ALUMUX2_S:   w_alu_b = regs_in.s_imm;
      ALUMUX2_RS2: w_alu_b = regs_in.rs2_out;
      ALUMUX2_J:   w_alu_b = regs_in.j_imm;
      default:     w_alu_b = '0;
    endcase
    w_cmp_b = (regs_in.ctrl.cmpmux_sel == CMPMUX_I) ? regs_in.i_imm : regs_in.rs2_out;
  end

  // ALU
  always_comb begin
    case (regs_in.ctrl.aluop)
      alu_add: w_alu_out = w_alu_a + w_alu_b;
      alu_sll: w_alu_out = w_alu_a << w_alu_b[4:0];
      alu_sra: w_alu_out = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
      alu_sub: w_alu_out = w_alu_a - w_alu_b;
      alu_xor: w_alu_out = w_alu_a ^ w_alu_b;
      alu_srl: w_alu_out = w_alu_a >> w_alu_b[4:0];
      alu_or:  w_alu_out = w_alu_a | w_alu_b;
      default: w_alu_out = w_alu_a & w_alu_b;
    endcase
  end

  // Branch comparator
  always_comb begin
    case (regs_in.ctrl.cmpop)
      beq:     w_br_en = (regs_in.rs1_out == w_cmp_b);
      bne:     w_br_en = (regs_in.rs1_out != w_cmp_b);
      blt:     w_br_en = ($signed(regs_in.rs1_out) < $signed(w_cmp_b));
      bge:     w_br_en = ($signed(regs_in.rs1_out) >= $signed(w_cmp_b));
      bltu:    w_br_en = (regs_in.rs1_out < w_cmp_b);
      bgeu:    w_br_en = (regs_in.rs1_out >= w_cmp_b);
      default: w_br_en = 1'b0;
    endcase
  end

  assign w_mop      = regs_in.valid & regs_in.ctrl.muldiv;
  assign w_load     = resp_a & resp_b & ~stall_in;
  assign w_md_start = w_mop & ~stall_in;
  assign w_md_ack   = w_load & w_mop & w_md_done;
  assign stall_out  = stall_in | (w_mop & ~w_md_done);

  muldiv_iter #(
    .WIDTH     (WIDTH),
    .EARLY_OUT (EARLY_OUT)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (w_md_start),
    .op     (muldiv_op_t'(regs_in.ctrl.funct3)),
    .a      (regs_in.rs1_out[WIDTH-1:0]),
    .b      (regs_in.rs2_out[WIDTH-1:0]),
    .ack    (w_md_ack),
    .done   (w_md_done),
    .result (w_md_result)
  );

  // Next stage contents: normal bundle, M result, or a bubble while the M unit works
  always_comb begin
    w_normal                = regs_in;
    w_normal.alu            = w_alu_out;
    w_normal.pc             = w_alu_out;
    w_normal.br             = {{(XLEN-1){1'b0}}, w_br_en};
    w_normal.ctrl.pcmux_sel = (w_br_en & (regs_in.ctrl.opcode == op_br)) |
                              (regs_in.ctrl.pcmux_sel &
                               ((regs_in.ctrl.opcode == op_jal) || (regs_in.ctrl.opcode == op_jalr)));
    w_next = w_normal;
    if (w_mop) begin
      if (w_md_done) begin
        w_next.alu = XLEN'(w_md_result);
      end else begin
        w_next.valid             = 1'b0;
        w_next.ctrl.load_regfile = 1'b0;
        w_next.ctrl.write        = 1'b0;
        w_next.ctrl.read_b       = 1'b0;
        w_next.ctrl.pcmux_sel    = 1'b0;
      end
    end
  end

  // Stage register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_regs <= '0;
    else if (w_load) r_regs <= w_next;
  end

  assign regs_out = r_regs;

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed, table-driven bench for execute_md (WIDTH=32, EARLY_OUT=1).
module tb_execute_md;
  import execute_md_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      resp_a, resp_b, stall_in;
  stage_regs regs_in, regs_out;
  logic      stall_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_md #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .resp_a    (resp_a),
    .resp_b    (resp_b),
    .stall_in  (stall_in),
    .regs_in   (regs_in),
    .regs_out  (regs_out),
    .stall_out (stall_out)
  );

  typedef struct {
    logic           md;
    rv32i_opcode    opc;
    logic [2:0]     fn;
    alu_ops         aluop;
    branch_funct3_t cmpop;
    alumux1_sel_t   m1;
    alumux2_sel_t   m2;
    cmpmux_sel_t    cm;
    logic           pcsel_in;
    rv32i_word      rs1, rs2, imm;
    rv32i_word      exp_alu;
    logic           exp_br;
    logic           exp_pcsel;
    int             exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t nrow(rv32i_opcode opc, alu_ops aop, branch_funct3_t cop,
                                alumux1_sel_t m1, alumux2_sel_t m2, cmpmux_sel_t cm,
                                logic pin, rv32i_word rs1, rv32i_word rs2, rv32i_word imm,
                                rv32i_word ea, logic eb, logic ep);
    vec_t v;
    v.md = 1'b0; v.opc = opc; v.fn = 3'd0; v.aluop = aop; v.cmpop = cop;
    v.m1 = m1; v.m2 = m2; v.cm = cm; v.pcsel_in = pin;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.exp_alu = ea; v.exp_br = eb; v.exp_pcsel = ep; v.exp_stall = 0;
    return v;
  endfunction

  function automatic vec_t mrow(logic [2:0] fn, rv32i_word rs1, rv32i_word rs2,
                                rv32i_word ea, int es);
    vec_t v;
    v = nrow(op_reg, alu_add, beq, ALUMUX1_RS1, ALUMUX2_RS2, CMPMUX_RS2, 1'b0,
             rs1, rs2, 32'd0, ea, 1'b0, 1'b0);
    v.md = 1'b1; v.fn = fn; v.exp_stall = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    regs_in                   = '0;
    regs_in.valid             = 1'b1;
    regs_in.ctrl.opcode       = v.opc;
    regs_in.ctrl.aluop        = v.aluop;
    regs_in.ctrl.cmpop        = v.cmpop;
    regs_in.ctrl.alumux1_sel  = v.m1;
    regs_in.ctrl.alumux2_sel  = v.m2;
    regs_in.ctrl.cmpmux_sel   = v.cm;
    regs_in.ctrl.pcmux_sel    = v.pcsel_in;
    regs_in.ctrl.load_regfile = 1'b1;
    regs_in.ctrl.muldiv       = v.md;
    regs_in.ctrl.funct3       = v.fn;
    regs_in.ctrl.rd           = 5'd7;
    regs_in.pc                = 32'h0000_1000;
    regs_in.rs1_out           = v.rs1;
    regs_in.rs2_out           = v.rs2;
    regs_in.i_imm             = v.imm;
    regs_in.u_imm             = 32'h0001_0000;
    regs_in.b_imm             = 32'h0000_0040;
    regs_in.s_imm             = 32'h0000_0020;
    regs_in.j_imm             = 32'h0000_0080;
  endtask

  // Apply one vector, count stall cycles (bubbles expected), then check the loaded result
  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic bub_bad;
    @(negedge clk);
    drive(v);
    resp_a = 1'b1; resp_b = 1'b1; stall_in = 1'b0;
    #1;
    n = 0;
    bub_bad = 1'b0;
    while (stall_out && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (regs_out.valid || regs_out.ctrl.load_regfile || regs_out.ctrl.pcmux_sel) bub_bad = 1'b1;
    end
    check($sformatf("v%0d stall_cycles", idx), 32'(n), 32'(v.exp_stall));
    if (v.md) check($sformatf("v%0d bubble", idx), {31'd0, bub_bad}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("v%0d alu", idx), regs_out.alu, v.exp_alu);
    check($sformatf("v%0d valid", idx), {31'd0, regs_out.valid}, 32'd1);
    if (!v.md) begin
      check($sformatf("v%0d br", idx), regs_out.br, {31'd0, v.exp_br});
      check($sformatf("v%0d pcmux", idx), {31'd0, regs_out.ctrl.pcmux_sel}, {31'd0, v.exp_pcsel});
    end
  endtask

  initial begin
    int n;
    vec_t v;

    // Single-cycle ALU / CMP / pcmux vectors
    vecs.push_back(nrow(op_imm,   alu_add, beq,  ALUMUX1_RS1, ALUMUX2_I,   CMPMUX_RS2, 1'b0, 32'd5, 32'd0, 32'd7, 32'd12, 1'b0, 1'b0));
    vecs.push_back(nrow(op_reg,   alu_sub, beq,  ALUMUX1_RS1, ALUMUX2_RS2, CMPMUX_RS2, 1'b0, 32'd10, 32'd3, 32'd0, 32'd7, 1'b0, 1'b0));
    vecs.push_back(nrow(op_auipc, alu_add, beq,  ALUMUX1_PC,  ALUMUX2_U,   CMPMUX_RS2, 1'b0, 32'd0, 32'd0, 32'd0, 32'h0001_1000, 1'b1, 1'b0));
    vecs.push_back(nrow(op_br,    alu_add, blt,  ALUMUX1_PC,  ALUMUX2_B,   CMPMUX_RS2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0000_1040, 1'b1, 1'b1));
    vecs.push_back(nrow(op_br,    alu_add, bltu, ALUMUX1_PC,  ALUMUX2_B,   CMPMUX_RS2, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0000_1040, 1'b0, 1'b0));
    vecs.push_back(nrow(op_jal,   alu_add, bne,  ALUMUX1_PC,  ALUMUX2_J,   CMPMUX_RS2, 1'b1, 32'd0, 32'd0, 32'd0, 32'h0000_1080, 1'b0, 1'b1));
    vecs.push_back(nrow(op_imm,   alu_sra, bge,  ALUMUX1_RS1, ALUMUX2_I,   CMPMUX_I,   1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b0, 1'b0));
    vecs.push_back(nrow(op_store, alu_xor, bgeu, ALUMUX1_RS1, ALUMUX2_S,   CMPMUX_RS2, 1'b0, 32'h0000_00FF, 32'd0, 32'd0, 32'h0000_00DF, 1'b1, 1'b0));
    vecs.push_back(nrow(op_reg,   alu_sll, beq,  ALUMUX1_RS1, ALUMUX2_RS2, CMPMUX_RS2, 1'b0, 32'd1, 32'd31, 32'd0, 32'h8000_0000, 1'b0, 1'b0));
    vecs.push_back(nrow(op_reg,   alu_or,  bne,  ALUMUX1_RS1, ALUMUX2_RS2, CMPMUX_RS2, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'd0, 32'h0000_00FF, 1'b1, 1'b0));
    vecs.push_back(nrow(op_jalr,  alu_and, beq,  ALUMUX1_RS1, ALUMUX2_I,   CMPMUX_I,   1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFE, 32'h0000_1234, 1'b0, 1'b1));
    vecs.push_back(nrow(op_imm,   alu_srl, blt,  ALUMUX1_RS1, ALUMUX2_I,   CMPMUX_I,   1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h0800_0000, 1'b1, 1'b0));
    // M ops: funct3, rs1, rs2, result, stall cycles (33 iterative, 1 early-out)
    vecs.push_back(mrow(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33));
    vecs.push_back(mrow(3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33));
    vecs.push_back(mrow(3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33));
    vecs.push_back(mrow(3'd2, 32'd2, 32'hFFFF_FFFF, 32'h0000_0001, 33));
    vecs.push_back(mrow(3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 33));
    vecs.push_back(mrow(3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF, 1));
    vecs.push_back(mrow(3'd6, 32'd9, 32'd0, 32'd9, 1));
    vecs.push_back(mrow(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1));
    vecs.push_back(mrow(3'd7, 32'd9, 32'd0, 32'd9, 1));
    vecs.push_back(mrow(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
    vecs.push_back(mrow(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1));
    vecs.push_back(mrow(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33));
    vecs.push_back(mrow(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33));
    vecs.push_back(mrow(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33));
    vecs.push_back(mrow(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33));
    vecs.push_back(mrow(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33));
    vecs.push_back(mrow(3'd7, 32'd100, 32'd7, 32'd2, 33));
    vecs.push_back(mrow(3'd4, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 1));
    vecs.push_back(mrow(3'd6, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 1));

    // Reset state
    reset = 1'b1; resp_a = 1'b1; resp_b = 1'b1; stall_in = 1'b0; regs_in = '0;
    repeat (2) @(negedge clk);
    check("reset regs_out zero", {31'd0, (regs_out == '0)}, 32'd1);
    check("reset stall_out", {31'd0, stall_out}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // stall_in in DONE for 3 cycles, then a memory-response gap, then the load
    @(negedge clk);
    v = mrow(3'd0, 32'd3, 32'd5, 32'd15, 33);
    drive(v);
    #1;
    n = 0;
    while (stall_out && n < 100) begin @(posedge clk); #1; n++; end
    check("done_hold reach done", 32'(n), 32'd33);
    stall_in = 1'b1;
    #1;
    check("done_hold stall_out", {31'd0, stall_out}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("done_hold no load", {31'd0, regs_out.valid}, 32'd0);
    end
    stall_in = 1'b0; resp_b = 1'b0;
    #1;
    check("done_hold still done", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    check("resp_gap no load", {31'd0, regs_out.valid}, 32'd0);
    resp_b = 1'b1;
    @(posedge clk); #1;
    check("done_hold result", regs_out.alu, 32'd15);
    check("done_hold valid", {31'd0, regs_out.valid}, 32'd1);

    // Reset while BUSY at count 10
    @(negedge clk);
    v = mrow(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
    drive(v);
    repeat (11) @(posedge clk);
    #2;
    check("busy bubble fields", regs_out.rs1_out, 32'hFFFF_FFFF);
    check("busy bubble valid", {31'd0, regs_out.valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("midop reset regs_out zero", {31'd0, (regs_out == '0)}, 32'd1);
    @(negedge clk);
    regs_in = '0;
    reset = 1'b0;
    #1;
    check("midop reset stall_out", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    check("idle nop no result", {31'd0, regs_out.valid}, 32'd0);
    run_vec(vecs[17], 100);

    // Non-M op with a memory response low: stage register holds
    @(negedge clk);
    drive(vecs[0]);
    resp_a = 1'b0;
    @(posedge clk); #1;
    check("resp_a low hold", regs_out.alu, 32'hFFFF_FFFF);
    resp_a = 1'b1;
    @(posedge clk); #1;
    check("resp_a restored load", regs_out.alu, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_md.md
# execute_md

Parametrised execute stage for the pipelined RV32 core. It extends the single-cycle ALU/CMP execute stage with an iterative RV32M multiply/divide unit, and is configurable in datapath width. It sits between decode and memory, consuming and producing `stage_regs`. It stalls upstream while a multi-cycle M-op is in flight and inserts bubbles downstream.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; sets the iteration count of the M unit.
- `EARLY_OUT`, 1: when 1, divide-by-zero and signed overflow skip iteration and complete in one cycle.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `resp_a` in 1: I-side memory response.
- `resp_b` in 1: D-side memory response.
- `stall_in` in 1: downstream stall.
- `regs_in` in `stage_regs`: decode-stage bundle.
- `regs_out` out `stage_regs`: registered bundle to the memory stage.
- `stall_out` out 1: stall to upstream stages.

## Operation
- Non-M ops use the existing rules:
  - alumux1 selects rs1 or pc.
  - alumux2 selects i/u/b/s imm, rs2 or j imm.
  - cmpmux selects rs2 or i_imm.
  - `regs.alu` and `regs.pc` carry the ALU result; `br` is `br_en` zero-extended.
  - `ctrl.pcmux_sel` = (br_en and op_br) or (pcmux_sel and (op_jal or op_jalr)).
  - All other fields pass through unchanged.
- An M-op is identified by `regs_in.valid` and `regs_in.ctrl.muldiv`. `funct3` selects mul, mulh, mulhsu, mulhu, div, divu, rem or remu.
- M-unit FSM, `muldiv_state_t`:
  - IDLE: on an M-op with `stall_in` low, latch |rs1| and |rs2| per signedness, plus the result sign and the op. Go to BUSY and set the counter to 0. If `EARLY_OUT` is set and this is a special case, go to DONE instead.
  - BUSY: one shift-add (mul, 2·WIDTH product) or restoring-subtract (div) step per cycle. After the step at counter = WIDTH-1, go to DONE.
  - DONE: the result is held, conditionally negated, with the high or low half selected. Go to IDLE on the cycle the stage register loads the M result.
- Special cases:
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Signed overflow (most-negative / -1): quotient = rs1, remainder = 0.
  - When `EARLY_OUT` = 0, these cases iterate fully and produce the same values.
- `stall_out` = `stall_in` or (an M-op is present and state ≠ DONE). The upstream stage holds `regs_in` while `stall_out` is high.
- Stage register load enable = `resp_a` and `resp_b` and not `stall_in`. What it loads:
  - M-op present and not DONE: a bubble, with `valid`=0, `load_regfile`=0, `write`=0, `read_b`=0 and `pcmux_sel`=0.
  - M-op in DONE: the M result in the `alu` field.
  - Otherwise: the normal bundle.
- Arithmetic:
  - Operands are WIDTH bits and the product is 2·WIDTH bits.
  - mulhsu treats rs1 as signed and rs2 as unsigned.
  - Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.

## Timing
- Reset: `regs_out` = all zeros (`valid`=0), state = IDLE, counter = 0. `stall_out` follows its combinational equation.
- Non-M latency: one edge. The result appears in `regs_out` after the first enabled edge.
- M latency, issue cycle t in IDLE:
  - BUSY occupies cycles t+1 through t+WIDTH.
  - DONE is cycle t+WIDTH+1.
  - `regs_out` updates at the end of cycle t+WIDTH+1 if enabled.
  - For WIDTH=32 this is the 34th edge.
- Early-out latency: DONE in cycle t+1, result at the end of t+1.
- Stalls:
  - `stall_in` high in DONE: stay in DONE and do not load.
  - Memory response low: same as `stall_in` high.
  - BUSY keeps iterating regardless of `stall_in` or memory responses.
- Reset mid-operation aborts to IDLE. Partial results are discarded and no bubble or result is emitted.
- Back-to-back M-ops: the second is seen in IDLE the cycle after DONE, with no extra gap.

## Structure
- `rv32i_types` additions:
  - `muldiv` bit in `rv32i_control_word`.
  - `muldiv_op_t` enum over funct3.
  - `muldiv_state_t` (IDLE, BUSY, DONE).
- Sub-module `muldiv_iter` (WIDTH):
  - Contains the FSM, counter, accumulator/quotient registers and special-case logic.
  - Handshake ports: `start`, `op`, `a`, `b`, `ack`, `done`, `result`.
- The top level keeps the ALU, CMP and muxes, the bubble insertion, and the `register` stage instance.

## Test plan
- add, rs1=5, i_imm=7, all enables high: `regs_out.alu`=12 after one edge, `stall_out`=0.
- mul, rs1=0xFFFFFFFF, rs2=2, WIDTH=32: `stall_out` high for 33 cycles with bubbles emitted, then `alu`=0xFFFFFFFE. mulhu on the same operands gives 1.
- div by zero, `EARLY_OUT`=1: rs1=9, rs2=0 gives 0xFFFFFFFF at the end of cycle t+1. rem on the same operands gives 9.
- div, rs1=0x80000000, rs2=0xFFFFFFFF: quotient 0x80000000. rem on the same operands gives 0.
- rem, rs1=-7, rs2=2: result -1 (0xFFFFFFFF). div on the same operands gives -3.
- `stall_in` held high for 3 cycles in DONE: no load and state stays DONE. Asserting `reset` at BUSY count 10 gives IDLE with `regs_out` all zero.
